// File: rtl/bus_requester.sv
// Bus requester: turns a single PE core memory request into an arbitrated
// shared-bus transaction, completing normally on ack or with an error on grant loss/timeout.
//
// state | meaning
// IDLE  | ready for a core request
// REQ   | request latched, bus_req raised, waiting for grant
// XFER  | granted, bus_valid driven, waiting for ack
// RESP  | one-cycle completion to the core, bus_req dropped
module bus_requester #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              core_valid,
    output logic              core_ready,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_err,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              bus_valid,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, XFER, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic       xfer_fail;

    // Only consulted in XFER, and only when there is no ack: ack always wins.
    assign xfer_fail = !bus_gnt || (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            core_rdata <= '0;
            core_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (core_valid) begin
                        bus_we    <= core_we;
                        bus_addr  <= core_addr;
                        bus_wdata <= core_wdata;
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
                        cnt <= 8'd0;
                    end
                end
                XFER: begin
                    cnt <= cnt + 8'd1;
                    if (bus_ack) begin
                        core_rdata <= bus_we ? '0 : bus_rdata;
                        core_err   <= 1'b0;
                    end else if (xfer_fail) begin
                        core_rdata <= '0;
                        core_err   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        core_ready  = 1'b0;
        bus_req     = 1'b0;
        bus_valid   = 1'b0;
        core_rvalid = 1'b0;
        case (state)
            IDLE: begin
                // Held low while reset is asserted even though the state is already IDLE.
                core_ready = reset_n;
                if (core_valid) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    state_nxt = XFER;
                end
            end
            XFER: begin
                bus_req   = 1'b1;
                bus_valid = 1'b1;
                if (bus_ack || xfer_fail) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                core_rvalid = 1'b1;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
